param_bus_cpu: RTL
==================

// Module: param_bus_cpu
// PURPOSE
//  Parametrised multicycle bus processor core: instruction register, 2-bit step counter, controller FSM,
//  NREG x WIDTH register file, accumulator ALU (A/G registers). Replaces the fixed 10-bit/4-reg datapath;
//  external data enters by valid/ready handshake instead of a tri-state enable. Adds carry/illegal flags.
//  Sits between debounced board I/O (switches, keys) and the LED/HEX output logic.
// PARAMETERS
//  WIDTH  10  data/instruction width; must satisfy WIDTH >= 4 + 2*RW
//  NREG   4   register count; power of 2, >= 2; RW = $clog2(NREG)
// PORTS
//  CLK        in   1      system clock, all state updates on rising edge
//  RSTb       in   1      asynchronous active-low reset
//  IN_DATA    in   WIDTH  instruction word / LDI immediate
//  IN_VALID   in   1      IN_DATA valid; transfer when IN_VALID & IN_READY at rising CLK
//  IN_READY   out  1      core accepts IN_DATA this cycle (combinational from state)
//  BUS_OUT    out  WIDTH  value on internal bus this cycle; 0 when nothing drives it
//  PEEK_SEL   in   RW     register index for debug read
//  PEEK_DATA  out  WIDTH  R[PEEK_SEL], combinational, pre-edge value
//  TSTEP      out  2      current step: 0 fetch, 1..3 execute
//  DONE       out  1      one-cycle pulse: instruction completed
//  CARRY      out  1      carry/borrow of last ADD/SUB
//  ILLEGAL    out  1      last fetched opcode was undefined
// BEHAVIOUR
//  Reset: all R[i], IR, A, G = 0; TSTEP=0; DONE=CARRY=ILLEGAL=0; BUS_OUT=0; IN_READY=1 (fetch step).
//  Reset mid-instruction abandons it: no register write, no DONE.
//  Encoding: OP=IR[WIDTH-1 -: 4], RA=IR[2*RW-1:RW], RB=IR[RW-1:0]; remaining bits ignored.
//  T0 FETCH: IN_READY=1; on transfer IR<=IN_DATA, TSTEP->1, ILLEGAL<=(OP>7). No transfer: stay T0.
//  Execute per OP (each step one cycle unless noted; final step returns TSTEP->0):
//   0 LDI : T1 IN_READY=1, waits in T1 until transfer; R[RA]<=IN_DATA, BUS_OUT=IN_DATA. Final.
//   1 MOV : T1 BUS_OUT=R[RB]; R[RA]<=R[RB]. Final.
//   2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: T1 BUS_OUT=R[RA], A<=R[RA];
//           T2 BUS_OUT=R[RB], G<=A op R[RB]; T3 BUS_OUT=G, R[RA]<=G. Final.
//   7 NOT : T1 A<=R[RA]; T2 G<=~A (BUS_OUT=0); T3 R[RA]<=G. Final.
//   8-15  : T1 no write, BUS_OUT=0. Final.
//  IN_READY=0 in all steps except T0 and LDI T1; IN_VALID while IN_READY=0 is ignored, data not consumed.
//  Arithmetic modulo 2^WIDTH. ADD: CARRY<=bit WIDTH of A+R[RB]. SUB: A-R[RB], CARRY<=1 iff borrow (A<R[RB]).
//  CARRY updates only at ADD/SUB T2; holds otherwise. ILLEGAL updates only at fetch.
//  DONE registered: high for exactly the cycle after the final-step edge (coincides with next T0).
//  RA==RB legal: operand read before write (ADD R1,R1 doubles R1).
//  Back-to-back: next instruction may transfer in the cycle DONE is high.
//  PEEK_DATA of the register being written shows old value until the write edge.
// TESTING
//  1 Reset then PEEK all regs -> 0; IN_READY=1, TSTEP=0, DONE=0.
//  2 LDI R1 with IN_VALID held low 3 cycles in T1, then IN_DATA=10'h155 -> R1=10'h155 after handshake,
//    DONE pulses one cycle, TSTEP 0->1(x4)->0.
//  3 R0=10'h3FF, R1=1; ADD R0,R1 -> R0=0, CARRY=1, DONE 4 cycles after fetch transfer;
//    SUB R1,R0 (1-0) -> R1=1, CARRY=0.
//  4 XOR R2,R2 with R2=10'h2AA -> R2=0; NOT R2 -> R2=10'h3FF; MOV R3,R2 -> R3=10'h3FF.
//  5 Opcode 4'hC fetched -> ILLEGAL=1, no reg changes, DONE after T1; next legal fetch clears ILLEGAL.
//  6 Assert RSTb low during ADD T2 -> R[RA] unchanged (0 after reset), no DONE;
//    rerun 2-4 with WIDTH=16, NREG=8.

Source files
------------

// File: rtl/param_bus_cpu_if.sv
// param_bus_cpu_if: input handshake and internal bus view of the core.
// Master drives IN_DATA/IN_VALID; slave (the core) drives IN_READY/BUS_OUT.
interface param_bus_cpu_if #(
  parameter int WIDTH = 10
) ();
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] BUS_OUT;

  modport master (
    output IN_DATA,
    output IN_VALID,
    input  IN_READY,
    input  BUS_OUT
  );

  modport slave (
    input  IN_DATA,
    input  IN_VALID,
    output IN_READY,
    output BUS_OUT
  );
endinterface

// File: rtl/param_bus_cpu.sv
// param_bus_cpu: multicycle accumulator CPU, NREG x WIDTH register file.
// Ports: CLK, RSTb, bus (handshake + BUS_OUT), PEEK_SEL/DATA, TSTEP, DONE, CARRY, ILLEGAL.
module param_bus_cpu #(
  parameter int WIDTH = 10,
  parameter int NREG  = 4
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  param_bus_cpu_if.slave           bus,
  input  logic [$clog2(NREG)-1:0]  PEEK_SEL,
  output logic [WIDTH-1:0]         PEEK_DATA,
  output logic [1:0]               TSTEP,
  output logic                     DONE,
  output logic                     CARRY,
  output logic                     ILLEGAL
);
  localparam int RW = $clog2(NREG);

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  step_t st_q, st_d;

  logic [WIDTH-1:0] rf [NREG];
  logic [3:0]       op_q;
  logic [RW-1:0]    ra_q;
  logic [RW-1:0]    rb_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic             c_q;
  logic             il_q;
  logic             dn_q;

  logic [WIDTH-1:0] ra_v;
  logic [WIDTH-1:0] rb_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;

  logic             is_ldi;
  logic             is_mov;
  logic             is_alu;
  logic             is_not;
  logic             is_bad;

  logic             rdy;
  logic [WIDTH-1:0] bus_v;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic             fetch;
  logic             a_ld;
  logic             g_ld;
  logic [WIDTH-1:0] g_d;
  logic             c_ld;
  logic             c_d;
  logic             fin;

  assign ra_v = rf[ra_q];
  assign rb_v = rf[rb_q];

  // Extra top bit carries out of ADD and flags a borrow out of SUB.
  assign sum = {1'b0, a_q} + {1'b0, rb_v};
  assign dif = {1'b0, a_q} - {1'b0, rb_v};

  assign is_bad = op_q[3];
  assign is_ldi = (op_q == OP_LDI);
  assign is_mov = (op_q == OP_MOV);
  assign is_not = (op_q == OP_NOT);
  assign is_alu = !is_bad && !is_ldi
               && !is_mov && !is_not;

  always_comb begin
    st_d  = st_q;
    rdy   = 1'b0;
    bus_v = '0;
    we    = 1'b0;
    wd    = '0;
    fetch = 1'b0;
    a_ld  = 1'b0;
    g_ld  = 1'b0;
    g_d   = '0;
    c_ld  = 1'b0;
    c_d   = 1'b0;
    fin   = 1'b0;
    unique case (st_q)
      T0: begin
        rdy = 1'b1;
        if (bus.IN_VALID) begin
          fetch = 1'b1;
          st_d  = T1;
        end
      end
      T1: begin
        unique case (1'b1)
          is_ldi: begin
            rdy   = 1'b1;
            bus_v = bus.IN_DATA;
            if (bus.IN_VALID) begin
              we  = 1'b1;
              wd  = bus.IN_DATA;
              fin = 1'b1;
            end
          end
          is_mov: begin
            bus_v = rb_v;
            we    = 1'b1;
            wd    = rb_v;
            fin   = 1'b1;
          end
          is_alu, is_not: begin
            bus_v = ra_v;
            a_ld  = 1'b1;
            st_d  = T2;
          end
          is_bad: begin
            fin = 1'b1;
          end
          default: begin
            fin = 1'b1;
          end
        endcase
      end
      T2: begin
        g_ld = 1'b1;
        st_d = T3;
        if (!is_not) bus_v = rb_v;
        unique case (op_q)
          OP_ADD: begin
            g_d  = sum[WIDTH-1:0];
            c_ld = 1'b1;
            c_d  = sum[WIDTH];
          end
          OP_SUB: begin
            g_d  = dif[WIDTH-1:0];
            c_ld = 1'b1;
            c_d  = dif[WIDTH];
          end
          OP_AND:  g_d = a_q & rb_v;
          OP_OR:   g_d = a_q | rb_v;
          OP_XOR:  g_d = a_q ^ rb_v;
          default: g_d = ~a_q;
        endcase
      end
      T3: begin
        bus_v = g_q;
        we    = 1'b1;
        wd    = g_q;
        fin   = 1'b1;
      end
      default: st_d = T0;
    endcase
    if (fin) st_d = T0;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) st_q <= T0;
    else       st_q <= st_d;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
      c_q  <= 1'b0;
      il_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      dn_q <= fin;
      if (fetch) begin
        op_q <= bus.IN_DATA[WIDTH-1 -: 4];
        ra_q <= bus.IN_DATA[2*RW-1:RW];
        rb_q <= bus.IN_DATA[RW-1:0];
        il_q <= bus.IN_DATA[WIDTH-1];
      end
      if (we)   rf[ra_q] <= wd;
      if (a_ld) a_q <= ra_v;
      if (g_ld) g_q <= g_d;
      if (c_ld) c_q <= c_d;
    end
  end

  assign bus.IN_READY = rdy;
  assign bus.BUS_OUT  = bus_v;
  assign PEEK_DATA    = rf[PEEK_SEL];
  assign TSTEP        = st_q;
  assign DONE         = dn_q;
  assign CARRY        = c_q;
  assign ILLEGAL      = il_q;
endmodule
